avmm_to_avst_fifo: RTL

- Parametrised Avalon-MM-write to Avalon-ST-source FIFO; next generation of the single-clock MM-to-ST FIFO bridge.
- The CPU writes payload words and per-word sideband (channel, error, sop, eop), and can read back fill level and status or flush the FIFO.
- The streaming side has a registered, show-ahead output with true valid/ready semantics.
- Sits between the HPS/Nios MM interconnect and a streaming consumer.

---
 rtl/avmm_to_avst_fifo.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/avmm_to_avst_fifo.sv
// Avalon-MM write slave feeding an Avalon-ST source through a single-clock FIFO.
// The CPU pushes payload words (addr 0) tagged with a sideband register (addr 1),
// reads the fill level (addr 2) and status (addr 3), and can flush via addr 3 bit 0.
// Storage is a (DEPTH-1)-entry RAM plus a show-ahead output register.
//
// Ports:
//   wrclock, reset                     single clock, async active-high reset
//   avalonmm_write_slave_*             MM slave: address/write/writedata/read,
//                                      readdata (latency 1), waitrequest
//   avalonst_source_*                  ST source: data/channel/error/sop/eop,
//                                      valid, ready
//   irq                                almost-full interrupt (optional)
//
// Optional feature: define AVST_FIFO_AFULL_IRQ_EN to add the almost-full
// threshold register (addr 3 bits [LEVEL_W+7:8]) and the irq output.
module avmm_to_avst_fifo #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned CHANNEL_W = 8,
  parameter int unsigned ERROR_W   = 8,
  parameter int unsigned LEVEL_W   = $clog2(DEPTH) + 1
) (
  input  logic                 wrclock,
  input  logic                 reset,
  input  logic [1:0]           avalonmm_write_slave_address,
  input  logic                 avalonmm_write_slave_write,
  input  logic [DATA_W-1:0]    avalonmm_write_slave_writedata,
  input  logic                 avalonmm_write_slave_read,
  output logic [31:0]          avalonmm_write_slave_readdata,
  output logic                 avalonmm_write_slave_waitrequest,
  output logic [DATA_W-1:0]    avalonst_source_data,
  output logic [CHANNEL_W-1:0] avalonst_source_channel,
  output logic [ERROR_W-1:0]   avalonst_source_error,
  output logic                 avalonst_source_startofpacket,
  output logic                 avalonst_source_endofpacket,
  output logic                 avalonst_source_valid,
`ifdef AVST_FIFO_AFULL_IRQ_EN
  output logic                 irq,
`endif
  input  logic                 avalonst_source_ready
);

  localparam int unsigned RamN = DEPTH - 1;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned EntW = DATA_W + CHANNEL_W + ERROR_W + 2;

  // Register-field view of writedata, zero-extended so narrow DATA_W still decodes.
  logic [DATA_W+31:0] wd_ext;
  logic [31:0]        wd;
  logic               unused_wd;
  assign wd_ext    = {32'd0, avalonmm_write_slave_writedata};
  assign wd        = wd_ext[31:0];
  assign unused_wd = ^wd_ext;

  logic [CHANNEL_W-1:0] sb_chan_q;
  logic [ERROR_W-1:0]   sb_err_q;
  logic                 sb_sop_q, sb_eop_q;

  logic [EntW-1:0]    ram_q [RamN];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d, ram_cnt;
  logic               valid_q, valid_d;
  logic [EntW-1:0]    out_q, out_d, push_entry;
  logic [31:0]        readdata_q, rd_d, rd_sb, rd_status;
  logic               full, empty, afull;
  logic               push, pop, load, flush, sb_wr, ctl_wr, ram_we;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RamN - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (level_q == LEVEL_W'(DEPTH));
  assign empty   = (level_q == '0);
  // Output register occupancy is part of level; the rest lives in the RAM.
  assign ram_cnt = level_q - LEVEL_W'(valid_q);

  assign avalonmm_write_slave_waitrequest = reset | full;

  assign push   = avalonmm_write_slave_write && (avalonmm_write_slave_address == 2'd0) &&
                  !avalonmm_write_slave_waitrequest;
  assign sb_wr  = avalonmm_write_slave_write && (avalonmm_write_slave_address == 2'd1);
  assign ctl_wr = avalonmm_write_slave_write && (avalonmm_write_slave_address == 2'd3);
  assign flush  = ctl_wr & wd[0];
  assign pop    = valid_q & avalonst_source_ready;
  assign load   = ~valid_q | pop;

  assign push_entry = {sb_eop_q, sb_sop_q, sb_err_q, sb_chan_q, avalonmm_write_slave_writedata};

  always_comb begin
    valid_d  = valid_q;
    out_d    = out_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ram_we   = 1'b0;
    level_d  = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
    if (load) begin
      if (ram_cnt != '0) begin
        out_d    = ram_q[rd_ptr_q];
        valid_d  = 1'b1;
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else if (push) begin
        // Nothing buffered: the incoming word bypasses the RAM.
        out_d   = push_entry;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
    if (push && !(load && (ram_cnt == '0))) begin
      ram_we   = 1'b1;
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    // Flush and push use different addresses, so they never coincide.
    if (flush) begin
      valid_d  = 1'b0;
      level_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge wrclock or posedge reset) begin
    if (reset) begin
      level_q  <= '0;
      valid_q  <= 1'b0;
      out_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      level_q  <= level_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge wrclock) begin
    if (ram_we) ram_q[wr_ptr_q] <= push_entry;
  end

  // Channel/error are sticky; sop/eop are one-shot per accepted word.
  always_ff @(posedge wrclock or posedge reset) begin
    if (reset) begin
      sb_chan_q <= '0;
      sb_err_q  <= '0;
      sb_sop_q  <= 1'b0;
      sb_eop_q  <= 1'b0;
    end else if (sb_wr) begin
      sb_chan_q <= wd[8 +: CHANNEL_W];
      sb_err_q  <= wd[16 +: ERROR_W];
      sb_sop_q  <= wd[24];
      sb_eop_q  <= wd[25];
    end else if (push) begin
      sb_sop_q <= 1'b0;
      sb_eop_q <= 1'b0;
    end
  end

`ifdef AVST_FIFO_AFULL_IRQ_EN
  logic [LEVEL_W-1:0] thr_q;
  logic               armed_q, irq_q;

  assign afull = (level_q >= thr_q);
  assign irq   = irq_q;

  // armed_q blocks a re-fire until afull has dropped at least once.
  always_ff @(posedge wrclock or posedge reset) begin
    if (reset) begin
      thr_q   <= LEVEL_W'(DEPTH - 4);
      armed_q <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      if (ctl_wr) thr_q <= wd[8 +: LEVEL_W];
      if (!afull) armed_q <= 1'b1;
      else if (armed_q) armed_q <= 1'b0;
      if (ctl_wr && wd[1]) irq_q <= 1'b0;
      else if (afull && armed_q) irq_q <= 1'b1;
    end
  end
`else
  assign afull = 1'b0;
`endif

  always_comb begin
    rd_sb                   = '0;
    rd_sb[8 +: CHANNEL_W]   = sb_chan_q;
    rd_sb[16 +: ERROR_W]    = sb_err_q;
    rd_sb[24]               = sb_sop_q;
    rd_sb[25]               = sb_eop_q;
    rd_status               = '0;
    rd_status[0]            = empty;
    rd_status[1]            = full;
    rd_status[2]            = afull;
`ifdef AVST_FIFO_AFULL_IRQ_EN
    rd_status[8 +: LEVEL_W] = thr_q;
`endif
    case (avalonmm_write_slave_address)
      2'd1:    rd_d = rd_sb;
      2'd2:    rd_d = 32'(level_q);
      2'd3:    rd_d = rd_status;
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge wrclock or posedge reset) begin
    if (reset) readdata_q <= '0;
    else if (avalonmm_write_slave_read) readdata_q <= rd_d;
  end

  assign avalonmm_write_slave_readdata = readdata_q;
  assign avalonst_source_valid         = valid_q;
  assign avalonst_source_data          = out_q[DATA_W-1:0];
  assign avalonst_source_channel       = out_q[DATA_W +: CHANNEL_W];
  assign avalonst_source_error         = out_q[DATA_W+CHANNEL_W +: ERROR_W];
  assign avalonst_source_startofpacket = out_q[EntW-2];
  assign avalonst_source_endofpacket   = out_q[EntW-1];

endmodule
